// File: rtl/fdct_mul_share_arbiter_if.sv
// Request and result channels between the fdct stages and the shared multiplier.
// The arbiter attaches through the slave modport; the fdct side uses master.
interface fdct_mul_share_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 14,
    parameter int P_WIDTH  = 29
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       res_valid;
    logic                       res_ready;
    logic [ID_WIDTH-1:0]        res_id;
    logic [P_WIDTH-1:0]         res_p;
    logic                       busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p, busy
    );
endinterface

// File: rtl/fdct_mul_share_arbiter.sv
// One signed-by-unsigned multiplier shared round-robin between NUM_REQ fdct requesters.
// Two-stage pipeline: registered operands, then registered tagged product with backpressure.
module fdct_mul_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 14,
    parameter int P_WIDTH  = 29
) (
    input logic                     ap_clk,
    input logic                     ap_rst_n,
    fdct_mul_share_arbiter_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_REQ);
    localparam int FULL_W = A_WIDTH + B_WIDTH;

    logic                r_s1Valid;
    logic [A_WIDTH-1:0]  r_s1A;
    logic [B_WIDTH-1:0]  r_s1B;
    logic [ID_WIDTH-1:0] r_s1Id;
    logic [ID_WIDTH-1:0] r_ptr;
    logic                r_resValid;
    logic [ID_WIDTH-1:0] r_resId;
    logic [P_WIDTH-1:0]  r_resP;

    logic                w_outAdv;
    logic                w_s1Adv;
    logic                w_found;
    logic                w_accept;
    logic [SEL_W-1:0]    w_sel;
    logic [SEL_W-1:0]    w_candSel;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_WIDTH-1:0] w_ptrNext;
    logic [A_WIDTH-1:0]  w_selA;
    logic [B_WIDTH-1:0]  w_selB;
    logic [A_WIDTH-1:0]  w_aArr [NUM_REQ];
    logic [B_WIDTH-1:0]  w_bArr [NUM_REQ];
    logic signed [FULL_W-1:0] w_aExt;
    logic signed [FULL_W-1:0] w_bExt;
    logic [P_WIDTH-1:0]  w_prod;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_aArr[i] = bus.req_a[i*A_WIDTH +: A_WIDTH];
        assign w_bArr[i] = bus.req_b[i*B_WIDTH +: B_WIDTH];
    end

    assign w_outAdv = !r_resValid || bus.res_ready;
    assign w_s1Adv  = !r_s1Valid || w_outAdv;

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_candSel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_candSel = SEL_W'((int'(r_ptr) + k) % NUM_REQ);
            if (bus.req_valid[w_candSel]) begin
                w_found = 1'b1;
                w_sel   = w_candSel;
            end
        end
    end

    assign w_grant       = w_found ? (NUM_REQ'(1) << w_sel) : '0;
    assign bus.req_ready = w_grant & {NUM_REQ{w_s1Adv & ap_rst_n}};
    assign w_accept      = w_found && w_s1Adv;
    assign w_ptrNext     = ID_WIDTH'((int'(w_sel) + 1) % NUM_REQ);
    assign w_selA        = w_aArr[w_sel];
    assign w_selB        = w_bArr[w_sel];

    // b is zero-extended so it stays non-negative; only the low product bits are kept.
    assign w_aExt = {{B_WIDTH{r_s1A[A_WIDTH-1]}}, r_s1A};
    assign w_bExt = {{A_WIDTH{1'b0}}, r_s1B};
    assign w_prod = P_WIDTH'(w_aExt * w_bExt);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1A      <= '0;
            r_s1B      <= '0;
            r_s1Id     <= '0;
            r_ptr      <= '0;
            r_resValid <= 1'b0;
            r_resId    <= '0;
            r_resP     <= '0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= w_accept;
                if (w_accept) begin
                    r_s1A  <= w_selA;
                    r_s1B  <= w_selB;
                    r_s1Id <= ID_WIDTH'(w_sel);
                    r_ptr  <= w_ptrNext;
                end
            end
            if (w_outAdv) begin
                r_resValid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_resP  <= w_prod;
                    r_resId <= r_s1Id;
                end
            end
        end
    end

    assign bus.res_valid = r_resValid;
    assign bus.res_id    = r_resId;
    assign bus.res_p     = r_resP;
    assign bus.busy      = r_s1Valid || r_resValid;
endmodule
